// File: rtl/traffic_light_pkg.sv
// Shared types and lamp encodings for the traffic-light sequencer.
// Lamp vectors are ordered {red, yellow, green}.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ST_RED,
        ST_RED_YLW,
        ST_GREEN,
        ST_YELLOW,
        ST_FLASH
    } tl_state_e;

    localparam logic [2:0] LAMPS_RED     = 3'b100;
    localparam logic [2:0] LAMPS_RED_YLW = 3'b110;
    localparam logic [2:0] LAMPS_GREEN   = 3'b001;
    localparam logic [2:0] LAMPS_YELLOW  = 3'b010;
    localparam logic [2:0] LAMPS_OFF     = 3'b000;

    function automatic logic [2:0] lamps_of(input tl_state_e s);
        logic [2:0] l;
        case (s)
            ST_RED:     l = LAMPS_RED;
            ST_RED_YLW: l = LAMPS_RED_YLW;
            ST_GREEN:   l = LAMPS_GREEN;
            ST_YELLOW:  l = LAMPS_YELLOW;
            ST_FLASH:   l = LAMPS_OFF;
            default:    l = LAMPS_RED;
        endcase
        return l;
    endfunction

    function automatic int max_of(input int a, input int b, input int c,
                                  input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/traffic_light_timer.sv
// Phase timer: counts up from zero, clears on request, flags the
// last cycle of a phase whose length is given by limit.
module traffic_light_timer
    import traffic_light_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign done = (cnt == limit - W'(1));

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore traffic-light sequencer RED -> RED+YELLOW -> GREEN -> YELLOW.
// Define TRAFFIC_LIGHT_FLASH_EN to add the flash input and FLASH state.
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int RED_T    = 10,
    parameter int REDYLW_T = 3,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int FLASH_T  = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef TRAFFIC_LIGHT_FLASH_EN
    input  logic flash,
`endif
    output logic red,
    output logic yellow,
    output logic green
);

    localparam int W =
        $clog2(max_of(RED_T, REDYLW_T, GREEN_T, YELLOW_T, FLASH_T)) + 1;

    if (RED_T < 1 || REDYLW_T < 1 || GREEN_T < 1 ||
        YELLOW_T < 1 || FLASH_T < 1) begin : g_bad_param
        $error("traffic_light_ctrl: all phase durations must be >= 1");
    end

    tl_state_e    state;
    tl_state_e    state_nx;
    logic [W-1:0] limit;
    logic         done;
    logic         clear;
    logic [2:0]   lamps;

    always_comb begin
        case (state)
            ST_RED:     limit = W'(RED_T);
            ST_RED_YLW: limit = W'(REDYLW_T);
            ST_GREEN:   limit = W'(GREEN_T);
            ST_YELLOW:  limit = W'(YELLOW_T);
            ST_FLASH:   limit = W'(FLASH_T);
            default:    limit = W'(RED_T);
        endcase
    end

    // Any state change restarts the timer so every phase begins at zero.
    assign clear = done | (state_nx != state);

    traffic_light_timer #(.W(W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .limit (limit),
        .done  (done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RED;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RED:     if (done) state_nx = ST_RED_YLW;
            ST_RED_YLW: if (done) state_nx = ST_GREEN;
            ST_GREEN:   if (done) state_nx = ST_YELLOW;
            ST_YELLOW:  if (done) state_nx = ST_RED;
`ifdef TRAFFIC_LIGHT_FLASH_EN
            ST_FLASH:   state_nx = ST_RED;
`endif
            default:    state_nx = ST_RED;
        endcase
`ifdef TRAFFIC_LIGHT_FLASH_EN
        if (flash) state_nx = ST_FLASH;
`endif
    end

    assign lamps = lamps_of(state);
    assign red   = lamps[2];
    assign green = lamps[0];

`ifdef TRAFFIC_LIGHT_FLASH_EN
    logic flash_ylw;

    // Held high outside FLASH so the lamp starts lit on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_ylw <= 1'b1;
        end else if (state != ST_FLASH) begin
            flash_ylw <= 1'b1;
        end else if (done) begin
            flash_ylw <= ~flash_ylw;
        end
    end

    assign yellow = lamps[1] | ((state == ST_FLASH) & flash_ylw);
`else
    assign yellow = lamps[1];
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a 6/2/6/2 instance and an all-1 instance
// checked each cycle against a phase-arithmetic reference model.
module tb_traffic_light_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic r, y, g;
    logic r1, y1, g1;
`ifdef TRAFFIC_LIGHT_FLASH_EN
    logic fl  = 1'b0;
    logic fl1 = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int t  = 0;
    int t1 = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .RED_T(6), .REDYLW_T(2), .GREEN_T(6), .YELLOW_T(2), .FLASH_T(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef TRAFFIC_LIGHT_FLASH_EN
        .flash  (fl),
`endif
        .red    (r),
        .yellow (y),
        .green  (g)
    );

    traffic_light_ctrl #(
        .RED_T(1), .REDYLW_T(1), .GREEN_T(1), .YELLOW_T(1), .FLASH_T(1)
    ) dut1 (
        .clk    (clk),
        .rst    (rst),
`ifdef TRAFFIC_LIGHT_FLASH_EN
        .flash  (fl1),
`endif
        .red    (r1),
        .yellow (y1),
        .green  (g1)
    );

    // Lamps {r,y,g} after t edges since reset release.
    function automatic logic [2:0] model(input int tt, input int a,
                                         input int b, input int c,
                                         input int d);
        int m;
        m = tt % (a + b + c + d);
        if (m < a)         return 3'b100;
        if (m < a + b)     return 3'b110;
        if (m < a + b + c) return 3'b001;
        return 3'b010;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic sample_all();
        chk("seq_6262", {r, y, g}, model(t, 6, 2, 6, 2));
        chk("seq_1111", {r1, y1, g1}, model(t1, 1, 1, 1, 1));
        chk("safety", {r & g, g & y, ~(r | y | g)}, 3'b000);
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        t1++;
        @(negedge clk);
        sample_all();
    endtask

    task automatic pulse_reset(input int off);
        #(off);
        rst = 1'b0;
        #1;
        chk("async_rst", {r, y, g}, 3'b100);
        chk("async_rst1", {r1, y1, g1}, 3'b100);
        @(negedge clk);
        chk("hold_rst", {r, y, g}, 3'b100);
        rst = 1'b1;
        t  = 0;
        t1 = 0;
        sample_all();
    endtask

    initial begin
        rst = 1'b0;
        #1;
        chk("rst_t1", {r, y, g}, 3'b100);
        chk("rst1_t1", {r1, y1, g1}, 3'b100);
        repeat (2) begin
            @(negedge clk);
            chk("rst_held", {r, y, g}, 3'b100);
        end
        rst = 1'b1;
        t  = 0;
        t1 = 0;
        sample_all();

        repeat (20) step();

        for (int i = 0; i < 16 && model(t, 6, 2, 6, 2) != 3'b001; i++)
            step();
        chk("in_green", {r, y, g}, 3'b001);
        step();
        pulse_reset(int'($urandom_range(1, 4)));
        repeat (18) step();

        repeat (6) begin
            repeat (int'($urandom_range(3, 40))) step();
            pulse_reset(int'($urandom_range(1, 4)));
        end
        repeat (20) step();

`ifdef TRAFFIC_LIGHT_FLASH_EN
        for (int i = 0; i < 16 && model(t, 6, 2, 6, 2) != 3'b001; i++)
            step();
        fl = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            t1++;
            @(negedge clk);
            chk("flash", {r, y, g}, ((k / 4) % 2 == 0) ? 3'b010 : 3'b000);
            chk("seq_1111", {r1, y1, g1}, model(t1, 1, 1, 1, 1));
        end
        fl = 1'b0;
        @(posedge clk);
        t = 0;
        t1++;
        @(negedge clk);
        sample_all();
        repeat (18) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
